// File: rtl/rgb_stream_packer_pkg.sv
// Shared sizes and pixel conversion helpers for the RGB stream packer.
package rgb_pack_pkg;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PIX_W      = 10;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned CNT_W      = 12;
  localparam int unsigned PTR_W      = $clog2(FIFO_DEPTH);
  localparam int unsigned USEDW_W    = $clog2(FIFO_DEPTH + 1);

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [7:0]        gray_t;

  function automatic word_t toRgb565(input pix_t r, input pix_t g, input pix_t b);
    return {r[PIX_W-1:PIX_W-5], g[PIX_W-1:PIX_W-6], b[PIX_W-1:PIX_W-5]};
  endfunction

  // Sum is two bits wider than a channel so R + 2G + B never wraps.
  function automatic gray_t toGray(input pix_t r, input pix_t g, input pix_t b);
    logic [PIX_W+1:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[PIX_W+1:4];
  endfunction

endpackage

// File: rtl/rgb_stream_packer_if.sv
// Pixel-in / FIFO-out signal bundle of the RGB stream packer.
interface rgb_stream_packer_if import rgb_pack_pkg::*; ();

  logic                iDVAL;
  pix_t                iRed;
  pix_t                iGreen;
  pix_t                iBlue;
  logic                iFRAME_START;
  logic                iRDREQ;
  word_t               oDATA;
  logic                oEMPTY;
  logic [USEDW_W-1:0]  oUSEDW;
  logic                oOVF;
  logic [CNT_W-1:0]    oPIX_CNT;

  modport master (
    output iDVAL, iRed, iGreen, iBlue, iFRAME_START, iRDREQ,
    input  oDATA, oEMPTY, oUSEDW, oOVF, oPIX_CNT
  );

  modport slave (
    input  iDVAL, iRed, iGreen, iBlue, iFRAME_START, iRDREQ,
    output oDATA, oEMPTY, oUSEDW, oOVF, oPIX_CNT
  );

endinterface

// File: rtl/rgb_stream_packer_fifo.sv
// pix_fifo4: 4x16 first-word-fall-through FIFO with occupancy output.
module pix_fifo4 import rgb_pack_pkg::*; (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iWrEn,
  input  word_t              iWrData,
  input  logic               iRdEn,
  output word_t              oData,
  output logic               oEmpty,
  output logic [USEDW_W-1:0] oUsedw
);

  localparam logic [USEDW_W-1:0] FullCnt = USEDW_W'(FIFO_DEPTH);

  word_t              mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [USEDW_W-1:0] count;
  logic               doPush;
  logic               doPop;

  // A pop frees the slot the write lands in, so a full FIFO can still accept.
  assign doPop  = iRdEn && (count != '0);
  assign doPush = iWrEn && ((count != FullCnt) || doPop);

  always_ff @(posedge iCLK) begin
    if (doPush) begin
      mem[wrPtr] <= iWrData;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head is forced to zero while empty so stale words never show after reset.
  assign oEmpty = (count == '0);
  assign oData  = oEmpty ? '0 : mem[rdPtr];
  assign oUsedw = count;

endmodule

// File: rtl/rgb_stream_packer.sv
// Packs valid pixels into 16-bit words and queues them in a 4-deep FIFO.
// Define RGBPACK_GRAY_EN to pack two 8-bit gray pixels per word instead of RGB565.
module rgb_stream_packer import rgb_pack_pkg::*; (
  input  logic               iCLK,
  input  logic               iRST,
  rgb_stream_packer_if.slave bus
);

  localparam logic [USEDW_W-1:0] FullCnt = USEDW_W'(FIFO_DEPTH);

  logic             wrEn;
  word_t            wrData;
  logic             drop;
  logic             ovf;
  logic [CNT_W-1:0] pixCnt;

`ifdef RGBPACK_GRAY_EN
  gray_t grayNow;
  gray_t grayHold;
  logic  oddPhase;

  assign grayNow = toGray(bus.iRed, bus.iGreen, bus.iBlue);

  // A pixel arriving with frame start is always the even half of a new pair.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      grayHold <= '0;
      oddPhase <= 1'b0;
    end else if (bus.iFRAME_START) begin
      grayHold <= bus.iDVAL ? grayNow : '0;
      oddPhase <= bus.iDVAL;
    end else if (bus.iDVAL) begin
      if (!oddPhase) grayHold <= grayNow;
      oddPhase <= !oddPhase;
    end
  end

  assign wrEn   = bus.iDVAL && oddPhase && !bus.iFRAME_START;
  assign wrData = {grayHold, grayNow};
`else
  assign wrEn   = bus.iDVAL;
  assign wrData = toRgb565(bus.iRed, bus.iGreen, bus.iBlue);
`endif

  pix_fifo4 u_fifo (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iWrEn   (wrEn),
    .iWrData (wrData),
    .iRdEn   (bus.iRDREQ),
    .oData   (bus.oDATA),
    .oEmpty  (bus.oEMPTY),
    .oUsedw  (bus.oUSEDW)
  );

  assign drop = wrEn && (bus.oUSEDW == FullCnt) && !bus.iRDREQ;

  // Counter counts every valid pixel, including dropped ones.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      ovf    <= 1'b0;
      pixCnt <= '0;
    end else begin
      if (drop)                  ovf <= 1'b1;
      else if (bus.iFRAME_START) ovf <= 1'b0;

      if (bus.iFRAME_START) pixCnt <= bus.iDVAL ? CNT_W'(1) : '0;
      else if (bus.iDVAL)   pixCnt <= pixCnt + 1'b1;
    end
  end

  assign bus.oOVF     = ovf;
  assign bus.oPIX_CNT = pixCnt;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// Directed self-checking bench for rgb_stream_packer.
module tb_rgb_stream_packer;

  logic iCLK = 1'b0;
  logic iRST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rgb_stream_packer_if bus ();

  rgb_stream_packer dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle();
    bus.iDVAL        = 1'b0;
    bus.iRed         = '0;
    bus.iGreen       = '0;
    bus.iBlue        = '0;
    bus.iFRAME_START = 1'b0;
    bus.iRDREQ       = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    iRST = 1'b0;
    step();
    step();
    iRST = 1'b1;
    step();
  endtask

  // One clock with the given inputs, then inputs return to idle.
  task automatic cyc(input logic dv, input logic [9:0] r, input logic [9:0] g,
                     input logic [9:0] b, input logic fs, input logic rd);
    bus.iDVAL        = dv;
    bus.iRed         = r;
    bus.iGreen       = g;
    bus.iBlue        = b;
    bus.iFRAME_START = fs;
    bus.iRDREQ       = rd;
    step();
    idle();
  endtask

  // Pixel k with every channel MSB field = k packs to {k[4:0], k[5:0], k[4:0]}.
  task automatic pix_k(input int k, input logic fs, input logic rd);
    cyc(1'b1, 10'(k << 5), 10'(k << 4), 10'(k << 5), fs, rd);
  endtask

`ifndef RGBPACK_GRAY_EN
  task automatic test_reset();
    idle();
    iRST = 1'b0;
    #3;
    checks++;
    if (bus.oDATA !== 16'h0 || bus.oEMPTY !== 1'b1 || bus.oUSEDW !== 3'd0 ||
        bus.oOVF !== 1'b0 || bus.oPIX_CNT !== 12'd0) begin
      errors++;
      $display("FAIL reset_state: got data=%h empty=%b usedw=%0d ovf=%b cnt=%0d want 0000 1 0 0 0",
               bus.oDATA, bus.oEMPTY, bus.oUSEDW, bus.oOVF, bus.oPIX_CNT);
    end
    step();
    iRST = 1'b1;
    step();
  endtask

  task automatic test_single_pixel();
    do_reset();
    bus.iDVAL  = 1'b1;
    bus.iRed   = 10'h3FF;
    bus.iGreen = 10'h000;
    bus.iBlue  = 10'h3FF;
    #2;
    checks++;
    if (bus.oEMPTY !== 1'b1) begin
      errors++;
      $display("FAIL single_empty_before: got %b want 1", bus.oEMPTY);
    end
    step();
    idle();
    checks++;
    if (bus.oEMPTY !== 1'b0 || bus.oDATA !== 16'hF81F) begin
      errors++;
      $display("FAIL single_word: got empty=%b data=%h want 0 f81f", bus.oEMPTY, bus.oDATA);
    end
    checks++;
    if (bus.oUSEDW !== 3'd1 || bus.oPIX_CNT !== 12'd1) begin
      errors++;
      $display("FAIL single_counts: got usedw=%0d cnt=%0d want 1 1", bus.oUSEDW, bus.oPIX_CNT);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp [4];
    exp = '{16'h0821, 16'h1042, 16'h1863, 16'h2084};
    do_reset();
    for (int k = 1; k <= 6; k++) pix_k(k, 1'b0, 1'b0);
    checks++;
    if (bus.oUSEDW !== 3'd4 || bus.oOVF !== 1'b1 || bus.oPIX_CNT !== 12'd6) begin
      errors++;
      $display("FAIL ovf_state: got usedw=%0d ovf=%b cnt=%0d want 4 1 6",
               bus.oUSEDW, bus.oOVF, bus.oPIX_CNT);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.oEMPTY !== 1'b0 || bus.oDATA !== exp[i]) begin
        errors++;
        $display("FAIL ovf_pop%0d: got empty=%b data=%h want 0 %h", i, bus.oEMPTY, bus.oDATA, exp[i]);
      end
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    end
    checks++;
    if (bus.oEMPTY !== 1'b1 || bus.oDATA !== 16'h0 || bus.oUSEDW !== 3'd0) begin
      errors++;
      $display("FAIL ovf_drained: got empty=%b data=%h usedw=%0d want 1 0000 0",
               bus.oEMPTY, bus.oDATA, bus.oUSEDW);
    end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    checks++;
    if (bus.oEMPTY !== 1'b1 || bus.oUSEDW !== 3'd0) begin
      errors++;
      $display("FAIL pop_when_empty: got empty=%b usedw=%0d want 1 0", bus.oEMPTY, bus.oUSEDW);
    end
    checks++;
    if (bus.oOVF !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", bus.oOVF);
    end
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    checks++;
    if (bus.oOVF !== 1'b0 || bus.oPIX_CNT !== 12'd0) begin
      errors++;
      $display("FAIL frame_clear: got ovf=%b cnt=%0d want 0 0", bus.oOVF, bus.oPIX_CNT);
    end
  endtask

  task automatic test_full_write_pop();
    logic [15:0] exp [4];
    exp = '{16'h1042, 16'h1863, 16'h2084, 16'h28A5};
    do_reset();
    pix_k(1, 1'b0, 1'b0);
    pix_k(2, 1'b0, 1'b0);
    pix_k(9, 1'b0, 1'b1);
    checks++;
    if (bus.oUSEDW !== 3'd2 || bus.oDATA !== 16'h1042) begin
      errors++;
      $display("FAIL mid_write_pop: got usedw=%0d data=%h want 2 1042", bus.oUSEDW, bus.oDATA);
    end
    do_reset();
    for (int k = 1; k <= 4; k++) pix_k(k, 1'b0, 1'b0);
    pix_k(5, 1'b0, 1'b1);
    checks++;
    if (bus.oUSEDW !== 3'd4 || bus.oOVF !== 1'b0) begin
      errors++;
      $display("FAIL full_write_pop: got usedw=%0d ovf=%b want 4 0", bus.oUSEDW, bus.oOVF);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.oDATA !== exp[i]) begin
        errors++;
        $display("FAIL full_order%0d: got %h want %h", i, bus.oDATA, exp[i]);
      end
      cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
    end
    // Full FIFO: a drop coinciding with frame start still flags overflow.
    for (int k = 1; k <= 4; k++) pix_k(k, 1'b0, 1'b0);
    pix_k(7, 1'b1, 1'b0);
    checks++;
    if (bus.oOVF !== 1'b1 || bus.oPIX_CNT !== 12'd1 || bus.oUSEDW !== 3'd4) begin
      errors++;
      $display("FAIL drop_at_frame: got ovf=%b cnt=%0d usedw=%0d want 1 1 4",
               bus.oOVF, bus.oPIX_CNT, bus.oUSEDW);
    end
  endtask

  task automatic test_pix_cnt_wrap();
    do_reset();
    for (int i = 0; i < 4095; i++) pix_k(i & 31, 1'b0, 1'b1);
    checks++;
    if (bus.oPIX_CNT !== 12'd4095) begin
      errors++;
      $display("FAIL cnt_4095: got %0d want 4095", bus.oPIX_CNT);
    end
    pix_k(1, 1'b0, 1'b0);
    checks++;
    if (bus.oPIX_CNT !== 12'd0) begin
      errors++;
      $display("FAIL cnt_wrap: got %0d want 0", bus.oPIX_CNT);
    end
    for (int k = 1; k <= 4; k++) pix_k(k, 1'b0, 1'b0);
    checks++;
    if (bus.oOVF !== 1'b1 || bus.oUSEDW !== 3'd4) begin
      errors++;
      $display("FAIL wrap_ovf: got ovf=%b usedw=%0d want 1 4", bus.oOVF, bus.oUSEDW);
    end
    pix_k(3, 1'b1, 1'b1);
    checks++;
    if (bus.oPIX_CNT !== 12'd1 || bus.oOVF !== 1'b0 || bus.oUSEDW !== 3'd4) begin
      errors++;
      $display("FAIL frame_with_pix: got cnt=%0d ovf=%b usedw=%0d want 1 0 4",
               bus.oPIX_CNT, bus.oOVF, bus.oUSEDW);
    end
  endtask

  task automatic test_midstream_reset();
    do_reset();
    for (int k = 1; k <= 3; k++) pix_k(k, 1'b0, 1'b0);
    #2;
    iRST = 1'b0;
    #1;
    checks++;
    if (bus.oEMPTY !== 1'b1 || bus.oUSEDW !== 3'd0 || bus.oDATA !== 16'h0 ||
        bus.oPIX_CNT !== 12'd0) begin
      errors++;
      $display("FAIL async_reset: got empty=%b usedw=%0d data=%h cnt=%0d want 1 0 0000 0",
               bus.oEMPTY, bus.oUSEDW, bus.oDATA, bus.oPIX_CNT);
    end
    step();
    iRST = 1'b1;
    step();
    pix_k(5, 1'b0, 1'b0);
    checks++;
    if (bus.oDATA !== 16'h28A5 || bus.oUSEDW !== 3'd1 || bus.oPIX_CNT !== 12'd1) begin
      errors++;
      $display("FAIL after_reset: got data=%h usedw=%0d cnt=%0d want 28a5 1 1",
               bus.oDATA, bus.oUSEDW, bus.oPIX_CNT);
    end
  endtask
`else
  task automatic test_gray_pairs();
    do_reset();
    // (400,400,400) -> 1600>>4 = 100 = 8'h64; (800,800,800) -> 3200>>4 = 200 = 8'hC8.
    cyc(1'b1, 10'd400, 10'd400, 10'd400, 1'b0, 1'b0);
    checks++;
    if (bus.oEMPTY !== 1'b1 || bus.oPIX_CNT !== 12'd1) begin
      errors++;
      $display("FAIL gray_hold: got empty=%b cnt=%0d want 1 1", bus.oEMPTY, bus.oPIX_CNT);
    end
    cyc(1'b1, 10'd800, 10'd800, 10'd800, 1'b0, 1'b0);
    checks++;
    if (bus.oUSEDW !== 3'd1 || bus.oDATA !== 16'h64C8) begin
      errors++;
      $display("FAIL gray_word: got usedw=%0d data=%h want 1 64c8", bus.oUSEDW, bus.oDATA);
    end
    cyc(1'b1, 10'd100, 10'd100, 10'd100, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    cyc(1'b1, 10'd16, 10'd16, 10'd16, 1'b0, 1'b0);
    checks++;
    if (bus.oUSEDW !== 3'd1) begin
      errors++;
      $display("FAIL gray_discard: got usedw=%0d want 1", bus.oUSEDW);
    end
    // Pixel with frame start is even: (64,64,64)->16, then (16,16,16)->4.
    cyc(1'b1, 10'd64, 10'd64, 10'd64, 1'b1, 1'b1);
    cyc(1'b1, 10'd16, 10'd16, 10'd16, 1'b0, 1'b0);
    checks++;
    if (bus.oUSEDW !== 3'd1 || bus.oDATA !== 16'h1004 || bus.oPIX_CNT !== 12'd2) begin
      errors++;
      $display("FAIL gray_frame_even: got usedw=%0d data=%h cnt=%0d want 1 1004 2",
               bus.oUSEDW, bus.oDATA, bus.oPIX_CNT);
    end
  endtask
`endif

  initial begin
    idle();
`ifndef RGBPACK_GRAY_EN
    test_reset();
    test_single_pixel();
    test_overflow();
    test_full_write_pop();
    test_pix_cnt_wrap();
    test_midstream_reset();
`else
    test_gray_pairs();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
